// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-RAM load controller.
package imem_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN_RST,
        RUN,
        HOLD,
        LOAD,
        RELEASE
    } imem_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic int unsigned imem_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Loader stream and CPU fetch port of the instruction-RAM controller.
// The master side is the loader/CPU; the slave side is the controller.
interface imem_load_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_instr;

    modport master (
        output ld_valid, ld_data, ld_last, fetch_addr,
        input  ld_ready, fetch_instr
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, fetch_addr,
        output ld_ready, fetch_instr
    );
endinterface

// File: rtl/imem_load_ctrl_sp_ram.sv
// Single-port instruction RAM with synchronous read; contents survive reset.
module imem_sp_ram
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned DEPTH = imem_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/imem_load_ctrl.sv
// Shares the instruction RAM between CPU fetch and a program loader stream.
// Optional macro IMEM_CHECKSUM_EN adds the ld_checksum output.
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int HOLD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    imem_load_ctrl_if.slave   bus,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              err_overflow
`ifdef IMEM_CHECKSUM_EN
    ,
    output logic [31:0]       ld_checksum
`endif
);
    localparam int HCNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    imem_state_e       state_q, state_d;
    logic [HCNT_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              fetch_ok_q;
    logic              load_entry;
    logic              handshake;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign bus.ld_ready = (state_q == LOAD);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        err_d      = err_q;
        load_entry = 1'b0;
        handshake  = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = bus.fetch_addr;

        unique case (state_q)
            RUN_RST: state_d = RUN;
            RUN: begin
                if (ld_start) begin
                    state_d = HOLD;
                    hold_d  = HCNT_W'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d    = LOAD;
                    wptr_d     = '0;
                    count_d    = '0;
                    err_d      = 1'b0;
                    load_entry = 1'b1;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            LOAD: begin
                // The RAM port belongs to the loader here; the core is held in reset.
                ram_addr  = wptr_q;
                handshake = bus.ld_valid & bus.ld_ready;
                if (handshake) begin
                    ram_we  = 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (bus.ld_last) begin
                        state_d = RELEASE;
                    end else if (&wptr_q) begin
                        err_d   = 1'b1;
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: state_d = RUN;
            default: state_d = RUN_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN_RST;
            hold_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            fetch_ok_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            fetch_ok_q <= (state_q == RUN);
        end
    end

    imem_sp_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(bus.ld_data),
        .rdata(ram_rdata)
    );

    // Read data is only trusted when the read was issued in RUN and we are still in RUN.
    assign bus.fetch_instr = (fetch_ok_q && state_q == RUN) ? ram_rdata : DATA_W'(NOP_INSTR);
    assign cpu_rst_n       = (state_q == RUN);
    assign load_done       = (state_q == RELEASE);
    assign load_count      = count_q;
    assign err_overflow    = err_q;

`ifdef IMEM_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (load_entry) begin
            csum_q <= '0;
        end else if (handshake) begin
            csum_q <= csum_q + 32'(bus.ld_data);
        end
    end

    assign ld_checksum = csum_q;
`endif
endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized bench for imem_load_ctrl with a timestamp-based reference model.
module tb_imem_load_ctrl;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;
    localparam int HOLD_CYC = 2;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NEVER    = 32'h3fff_ffff;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_start;
    logic              cpu_rst_n;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              err_overflow;
`ifdef IMEM_CHECKSUM_EN
    logic [31:0]       ld_checksum;
`endif

    imem_load_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_load_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_start    (ld_start),
        .bus         (bus),
        .cpu_rst_n   (cpu_rst_n),
        .load_done   (load_done),
        .load_count  (load_count),
        .err_overflow(err_overflow)
`ifdef IMEM_CHECKSUM_EN
        ,
        .ld_checksum (ld_checksum)
`endif
    );

    always #5 clk = ~clk;

    int  n_vec = 0;
    int  n_miss = 0;
    int  cyc = 0;
    bit  model_on = 1'b0;
    bit  rand_fetch = 1'b0;
    int  low_total = 0;
    int  done_total = 0;

    // Model: phases are tracked as cycle timestamps rather than states.
    int          run_from = NEVER;
    int          load_from = NEVER;
    int          load_end = NEVER;
    int          done_at = -1;
    int          exp_count = 0;
    bit          exp_err = 1'b0;
    logic [31:0] exp_csum = '0;
    logic [31:0] exp_fetch = NOP;
    bit          fetch_known = 1'b1;
    logic [31:0] mem_m [DEPTH];
    bit          known_m [DEPTH];

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endfunction

    always @(posedge clk) begin
        int k;
        bit was_run, was_ready;
        cyc = cyc + 1;
        k = cyc;
        if (!rst_n) begin
            run_from  = k + 1;
            load_from = NEVER;
            load_end  = NEVER;
            done_at   = -1;
            exp_count = 0;
            exp_err   = 1'b0;
            exp_csum  = '0;
            exp_fetch = NOP;
            fetch_known = 1'b1;
            model_on  = 1'b1;
        end else begin
            was_run   = (k - 1 >= run_from);
            was_ready = (k - 1 >= load_from) && (k - 1 < load_end);
            if (was_run && ld_start) begin
                run_from  = NEVER;
                load_from = k + HOLD_CYC;
                load_end  = NEVER;
            end
            if (was_ready && bus.ld_valid) begin
                mem_m[exp_count]   = bus.ld_data;
                known_m[exp_count] = 1'b1;
                exp_count++;
                exp_csum = exp_csum + bus.ld_data;
                if (bus.ld_last || exp_count == DEPTH) begin
                    if (!bus.ld_last) exp_err = 1'b1;
                    load_end = k;
                    done_at  = k;
                    run_from = k + 1;
                end
            end
            if (k == load_from) begin
                exp_count = 0;
                exp_err   = 1'b0;
                exp_csum  = '0;
            end
            if (was_run && k >= run_from) begin
                exp_fetch   = mem_m[bus.fetch_addr];
                fetch_known = known_m[bus.fetch_addr];
            end else begin
                exp_fetch   = NOP;
                fetch_known = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!cpu_rst_n) low_total++;
        if (load_done) done_total++;
        if (model_on) begin
            checkOutput("cpu_rst_n", 32'(cpu_rst_n), 32'(cyc >= run_from));
            checkOutput("ld_ready", 32'(bus.ld_ready), 32'(cyc >= load_from && cyc < load_end));
            checkOutput("load_done", 32'(load_done), 32'(cyc == done_at));
            checkOutput("load_count", 32'(load_count), exp_count);
            checkOutput("err_overflow", 32'(err_overflow), 32'(exp_err));
            if (fetch_known) checkOutput("fetch_instr", bus.fetch_instr, exp_fetch);
`ifdef IMEM_CHECKSUM_EN
            checkOutput("ld_checksum", ld_checksum, exp_csum);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (rand_fetch) bus.fetch_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
    endtask

    task automatic applyStimulus(input bit start, input bit valid, input logic [31:0] data,
                                 input bit last);
        ld_start     = start;
        bus.ld_valid = valid;
        bus.ld_data  = data;
        bus.ld_last  = last;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic waitRun();
        for (int t = 0; t < 30 && !cpu_rst_n; t++) applyStimulus(0, 0, 32'h0, 0);
        if (!cpu_rst_n) checkOutput("wait_run", 32'(cpu_rst_n), 32'd1);
    endtask

    task automatic startLoad();
        bit seen = 1'b0;
        waitRun();
        applyStimulus(1, 0, 32'h0, 0);
        for (int t = 0; t < HOLD_CYC + 4 && !seen; t++) begin
            if (bus.ld_ready) seen = 1'b1;
            else applyStimulus(0, 0, 32'h0, 0);
        end
        if (!seen) checkOutput("start_to_ready", 32'(bus.ld_ready), 32'd1);
    endtask

    task automatic sendWord(input logic [31:0] data, input bit last, input int gap, output bit ok);
        bit hs;
        ok = 1'b0;
        for (int g = 0; g < gap; g++)
            applyStimulus(bit'($urandom_range(0, 1)) & bus.ld_ready, 0, 32'h0, 0);
        for (int t = 0; t < 12 && !ok; t++) begin
            hs = bus.ld_ready;
            applyStimulus(0, 1, data, last);
            ok = hs;
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic fetchCheck(input string name, input int addr, input logic [31:0] expected);
        bus.fetch_addr = ADDR_W'(addr);
        applyStimulus(0, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0);
        checkOutput(name, bus.fetch_instr, expected);
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        applyStimulus(0, 0, 32'h0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        bit ok;
        int acc, low0, done0, len, nxt;
        logic [31:0] w4 [4];
        w4[0] = 32'h11; w4[1] = 32'h22; w4[2] = 32'h33; w4[3] = 32'h44;
        rst_n = 1'b0;
        ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data = '0;
        bus.ld_last = 1'b0;
        bus.fetch_addr = '0;
        for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;

        repeat (3) tick();
        checkOutput("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("rst_fetch_nop", bus.fetch_instr, NOP);
        checkOutput("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        checkOutput("rst_load_count", 32'(load_count), 32'd0);
        rst_n = 1'b1;
        checkOutput("release_cyc1", 32'(cpu_rst_n), 32'd0);
        tick();
        checkOutput("release_cyc2", 32'(cpu_rst_n), 32'd1);

        // Known program in every word so later reads have defined expectations.
        startLoad();
        for (int i = 0; i < DEPTH; i++) sendWord(32'h100 + i, i == DEPTH - 1, 0, ok);
        waitRun();
        fetchCheck("preload_w5", 5, 32'h105);

        low0 = low_total;
        done0 = done_total;
        startLoad();
        for (int i = 0; i < 4; i++) sendWord(w4[i], i == 3, 0, ok);
        waitRun();
        checkOutput("load4_low_cycles", low_total - low0, HOLD_CYC + 5);
        checkOutput("load4_done_pulses", done_total - done0, 32'd1);
        checkOutput("load4_count", 32'(load_count), 32'd4);
        checkOutput("model_count4", exp_count, 32'd4);
        fetchCheck("load4_w3", 3, 32'h44);
        fetchCheck("load4_w4_old", 4, 32'h104);

        startLoad();
        for (int i = 0; i < 3; i++) sendWord(32'hA0 + i, i == 2, (i == 0) ? 0 : 1, ok);
        waitRun();
        checkOutput("stall_count", 32'(load_count), 32'd3);
        fetchCheck("stall_w3_kept", 3, 32'h44);

        startLoad();
        acc = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            sendWord(32'hC0 + i, 1'b0, 0, ok);
            acc += int'(ok);
        end
        checkOutput("ovf_accepted", acc, DEPTH);
        checkOutput("ovf_count", 32'(load_count), DEPTH);
        checkOutput("ovf_err", 32'(err_overflow), 32'd1);
        checkOutput("ovf_ready_low", 32'(bus.ld_ready), 32'd0);
        pulseReset();
        checkOutput("rst_clears_err", 32'(err_overflow), 32'd0);

        startLoad();
        sendWord(32'hE0, 1'b0, 0, ok);
        sendWord(32'hE1, 1'b0, 0, ok);
        pulseReset();
        checkOutput("abort_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("abort_ld_ready", 32'(bus.ld_ready), 32'd0);
        checkOutput("abort_count", 32'(load_count), 32'd0);
        waitRun();
        fetchCheck("abort_w0", 0, 32'hE0);
        fetchCheck("abort_w1", 1, 32'hE1);
        fetchCheck("abort_w2_old", 2, 32'hC2);

`ifdef IMEM_CHECKSUM_EN
        startLoad();
        sendWord(32'hFFFF_FFFF, 1'b0, 0, ok);
        sendWord(32'h2, 1'b1, 0, ok);
        waitRun();
        checkOutput("checksum_wrap", ld_checksum, 32'h1);
`endif

        rand_fetch = 1'b1;
        for (int r = 0; r < 40; r++) begin
            startLoad();
            len = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < len; i++) begin
                sendWord($urandom, (i == len - 1) && (len <= DEPTH), $urandom_range(0, 2), ok);
                if (!ok) break;
                if ($urandom_range(0, 15) == 0) begin
                    pulseReset();
                    break;
                end
            end
            nxt = $urandom_range(0, 5);
            for (int i = 0; i < nxt; i++) applyStimulus(0, bit'($urandom_range(0, 1)), $urandom, 0);
        end
        waitRun();
        repeat (4) applyStimulus(0, 0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
